// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: register-file writeback scheduler.
// Takes results from NUM_REQ producers over valid/ready handshakes and holds
// each one in a one-entry buffer per producer. Up to two buffered results per
// cycle are issued onto the two registered register-file write ports. Two
// writes to the same register are never issued in the same cycle.
// Build option: define RF_WB_RR_EN for round-robin priority. Without it, the
// priority is fixed and requester 0 is highest.
module rf_wb_arbiter #(
   parameter int unsigned OPRAND_WIDTH  = 16,
   parameter int unsigned REGNAME_WIDTH = 5,
   parameter int unsigned NUM_REQ       = 4
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic                                        flush_i,
   input  logic [NUM_REQ-1:0]                          req_valid_i,
   output logic [NUM_REQ-1:0]                          req_ready_o,
   input  logic [NUM_REQ-1:0][REGNAME_WIDTH-1:0]       req_target_i,
   input  logic [NUM_REQ-1:0][OPRAND_WIDTH-1:0]        req_data_i,
   output logic                                        WB_en1,
   output logic                                        WB_en2,
   output logic [REGNAME_WIDTH-1:0]                    WB_target1,
   output logic [REGNAME_WIDTH-1:0]                    WB_target2,
   output logic [OPRAND_WIDTH-1:0]                     WB_data1,
   output logic [OPRAND_WIDTH-1:0]                     WB_data2,
   output logic                                        busy_o
);

   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   // Holding buffers, one per requester
   logic [NUM_REQ-1:0]                    full_q;
   logic [NUM_REQ-1:0][REGNAME_WIDTH-1:0] tgt_q;
   logic [NUM_REQ-1:0][OPRAND_WIDTH-1:0]  data_q;

   // Arbitration results
   logic [IDX_W-1:0]   ptr_q;
   logic [IDX_W-1:0]   rot_idx;
   logic               g1_vld;
   logic               g2_vld;
   logic [IDX_W-1:0]   g1_idx;
   logic [IDX_W-1:0]   g2_idx;
   logic [NUM_REQ-1:0] grant;
   logic [NUM_REQ-1:0] accept;

   // Scan the full buffers in rotation order from the pointer.
   // Slot 1 takes the first full buffer. Slot 2 takes the next full buffer
   // whose target differs from slot 1's target.
   always_comb begin : arbitrate
      g1_vld  = 1'b0;
      g2_vld  = 1'b0;
      g1_idx  = '0;
      g2_idx  = '0;
      rot_idx = '0;
      grant   = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         rot_idx = IDX_W'((32'(ptr_q) + i) % NUM_REQ);
         if (full_q[rot_idx]) begin
            if (!g1_vld) begin
               g1_vld = 1'b1;
               g1_idx = rot_idx;
            end else if (!g2_vld && (tgt_q[rot_idx] != tgt_q[g1_idx])) begin
               g2_vld = 1'b1;
               g2_idx = rot_idx;
            end
         end
      end
      if (g1_vld) grant[g1_idx] = 1'b1;
      if (g2_vld) grant[g2_idx] = 1'b1;
   end

   // A buffer can accept when it is empty or is draining this cycle.
   // The grant looks only at held state, so there is no path from valid to ready.
   assign req_ready_o = {NUM_REQ{!flush_i}} & (~full_q | grant);
   assign accept      = req_valid_i & req_ready_o;

   // Capture accepted results. Granted buffers drain unless refilled in the same cycle.
   always_ff @(posedge clk or negedge rst) begin : hold_bufs
      if (!rst) begin
         full_q <= '0;
         tgt_q  <= '0;
         data_q <= '0;
      end else if (flush_i) begin
         full_q <= '0;
      end else begin
         for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (accept[k]) begin
               full_q[k] <= 1'b1;
               tgt_q[k]  <= req_target_i[k];
               data_q[k] <= req_data_i[k];
            end else if (grant[k]) begin
               full_q[k] <= 1'b0;
            end
         end
      end
   end

   // Register the granted entries onto the write ports. An idle slot keeps its address and data.
   always_ff @(posedge clk or negedge rst) begin : wb_ports
      if (!rst) begin
         WB_en1     <= 1'b0;
         WB_en2     <= 1'b0;
         WB_target1 <= '0;
         WB_target2 <= '0;
         WB_data1   <= '0;
         WB_data2   <= '0;
      end else begin
         WB_en1 <= g1_vld && !flush_i;
         WB_en2 <= g2_vld && !flush_i;
         if (g1_vld && !flush_i) begin
            WB_target1 <= tgt_q[g1_idx];
            WB_data1   <= data_q[g1_idx];
         end
         if (g2_vld && !flush_i) begin
            WB_target2 <= tgt_q[g2_idx];
            WB_data2   <= data_q[g2_idx];
         end
      end
   end

   assign busy_o = (|full_q) | WB_en1 | WB_en2;

`ifdef RF_WB_RR_EN
   logic [IDX_W-1:0] ptr_d;

   function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
      return IDX_W'((32'(idx) + 32'd1) % NUM_REQ);
   endfunction

   // After any grant, move the pointer to one past the last granted requester in rotation order.
   always_comb begin : ptr_next
      ptr_d = ptr_q;
      if (!flush_i) begin
         if (g2_vld)      ptr_d = wrap_inc(g2_idx);
         else if (g1_vld) ptr_d = wrap_inc(g1_idx);
      end
   end

   // Round-robin pointer register
   always_ff @(posedge clk or negedge rst) begin : ptr_reg
      if (!rst) ptr_q <= '0;
      else      ptr_q <= ptr_d;
   end
`else
   assign ptr_q = '0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter. Each handshake pushes an expected write
// onto a scoreboard. Each issued write must match a queued entry and must be
// the oldest entry still held for its requester.
module tb_rf_wb_arbiter;

   localparam int OW = 16;
   localparam int RW = 5;
   localparam int NR = 4;

   typedef struct packed {
      logic [2:0]    req;
      logic [RW-1:0] tgt;
      logic [OW-1:0] data;
   } sb_t;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     flush_i;
   logic [NR-1:0]            req_valid_i;
   logic [NR-1:0]            req_ready_o;
   logic [NR-1:0][RW-1:0]    req_target_i;
   logic [NR-1:0][OW-1:0]    req_data_i;
   logic                     WB_en1, WB_en2;
   logic [RW-1:0]            WB_target1, WB_target2;
   logic [OW-1:0]            WB_data1, WB_data2;
   logic                     busy_o;

   int            total = 0;
   int            bad   = 0;
   sb_t           sbq[$];
   logic [NR-1:0] hs_mask;
   logic [NR-1:0] gmask;
   logic [NR-1:0] gm_prev;
   int            cnt[NR];
   int            who;

   always #5 clk = ~clk;

   rf_wb_arbiter #(.OPRAND_WIDTH(OW), .REGNAME_WIDTH(RW), .NUM_REQ(NR)) dut (
      .clk(clk), .rst(rst), .flush_i(flush_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_target_i(req_target_i), .req_data_i(req_data_i),
      .WB_en1(WB_en1), .WB_en2(WB_en2),
      .WB_target1(WB_target1), .WB_target2(WB_target2),
      .WB_data1(WB_data1), .WB_data2(WB_data2),
      .busy_o(busy_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int k, input logic [RW-1:0] t, input logic [OW-1:0] d);
      req_valid_i[k]  = 1'b1;
      req_target_i[k] = t;
      req_data_i[k]   = d;
   endtask

   // Match an issued write against the oldest queued entry of some requester
   task automatic sb_write(input string tag, input logic [RW-1:0] t, input logic [OW-1:0] d,
                           output int w);
      int j;
      bit ok;
      j = -1;
      w = -1;
      foreach (sbq[i]) if (j < 0 && sbq[i].tgt == t && sbq[i].data == d) j = i;
      ok = (j >= 0);
      if (ok) for (int i = 0; i < j; i++) if (sbq[i].req == sbq[j].req) ok = 1'b0;
      total++;
      assert (ok === 1'b1) else begin
         bad++;
         $error("FAIL %s observed t=%0d d=%h expected=oldest queued entry of its requester (queued=%0d)",
                tag, t, d, sbq.size());
      end
      if (j >= 0) begin
         w = int'(sbq[j].req);
         sbq.delete(j);
      end
   endtask

   // One clock: record handshakes, cross the edge, then check the issued writes
   task automatic cyc();
      sb_t e;
      int  w;
      hs_mask = '0;
      #1;
      if (!flush_i) begin
         for (int k = 0; k < NR; k++) begin
            if (req_valid_i[k] && req_ready_o[k]) begin
               e.req  = 3'(k);
               e.tgt  = req_target_i[k];
               e.data = req_data_i[k];
               sbq.push_back(e);
               hs_mask[k] = 1'b1;
            end
         end
      end
      @(posedge clk);
      #1;
      gmask = '0;
      if (flush_i) sbq.delete();
      if (WB_en1) begin
         sb_write("sb_wb1", WB_target1, WB_data1, w);
         if (w >= 0) gmask[w] = 1'b1;
      end
      if (WB_en2) begin
         sb_write("sb_wb2", WB_target2, WB_data2, w);
         if (w >= 0) gmask[w] = 1'b1;
      end
      if (WB_en1 && WB_en2) chk("wb_tgt_distinct", 32'(WB_target1 != WB_target2), 32'd1);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b0;
      flush_i      = 1'b0;
      req_valid_i  = '1;
      req_target_i = '0;
      req_data_i   = '1;

      // Reset with valids high: nothing is issued
      repeat (2) @(negedge clk);
      chk("rst_en1",  32'(WB_en1), 32'd0);
      chk("rst_en2",  32'(WB_en2), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      rst         = 1'b1;
      req_valid_i = '0;
      #1;
      chk("rst_ready", 32'(req_ready_o), 32'hF);

      // Two requesters in one cycle: both ports write two cycles later
      set_req(0, 5'd3, 16'h1111);
      set_req(1, 5'd7, 16'h2222);
      cyc();
      req_valid_i = '0;
      chk("lat_n1_en1", 32'(WB_en1), 32'd0);
      chk("lat_n1_busy", 32'(busy_o), 32'd1);
      cyc();
      chk("two_en1",  32'(WB_en1), 32'd1);
      chk("two_tgt1", 32'(WB_target1), 32'd3);
      chk("two_dat1", 32'(WB_data1), 32'h1111);
      chk("two_en2",  32'(WB_en2), 32'd1);
      chk("two_tgt2", 32'(WB_target2), 32'd7);
      chk("two_dat2", 32'(WB_data2), 32'h2222);
      cyc();
      chk("two_idle_en", 32'({WB_en1, WB_en2}), 32'd0);
      chk("two_idle_busy", 32'(busy_o), 32'd0);

      // Same target: the second write issues one cycle later, always on port 1
      set_req(0, 5'd5, 16'hAAAA);
      set_req(1, 5'd5, 16'hBBBB);
      cyc();
      req_valid_i = '0;
      cyc();
      chk("same_a_en1", 32'(WB_en1), 32'd1);
      chk("same_a_tgt", 32'(WB_target1), 32'd5);
      chk("same_a_dat", 32'(WB_data1), 32'hAAAA);
      chk("same_a_en2", 32'(WB_en2), 32'd0);
      cyc();
      chk("same_b_en1", 32'(WB_en1), 32'd1);
      chk("same_b_tgt", 32'(WB_target1), 32'd5);
      chk("same_b_dat", 32'(WB_data1), 32'hBBBB);
      chk("same_b_en2", 32'(WB_en2), 32'd0);
      cyc();
      chk("same_idle_busy", 32'(busy_o), 32'd0);

      // One requester streams one result per cycle
      for (int c = 1; c <= 9; c++) begin
         if (c <= 8) begin
            set_req(2, 5'(c), 16'(c));
            #1;
            chk("stream_ready", 32'(req_ready_o[2]), 32'd1);
         end else begin
            req_valid_i = '0;
         end
         cyc();
         if (c >= 2) begin
            chk("stream_en1", 32'(WB_en1), 32'd1);
            chk("stream_tgt", 32'(WB_target1), 32'(c - 1));
            chk("stream_dat", 32'(WB_data1), 32'(c - 1));
            chk("stream_en2", 32'(WB_en2), 32'd0);
         end
      end
      cyc();
      chk("stream_idle", 32'(WB_en1), 32'd0);

      // Oversubscription: all requesters hold valid continuously
      for (int k = 0; k < NR; k++) cnt[k] = 0;
      gm_prev = '0;
      for (int c = 0; c < 10; c++) begin
         for (int k = 0; k < NR; k++) set_req(k, 5'(16 + k), 16'((k << 12) | cnt[k]));
         cyc();
         for (int k = 0; k < NR; k++) if (hs_mask[k]) cnt[k]++;
         if (c >= 1) chk("ovs_dual", 32'({WB_en1, WB_en2}), 32'd3);
         if (c >= 2) begin
`ifdef RF_WB_RR_EN
            chk("ovs_fair", 32'(gmask | gm_prev), 32'hF);
`else
            chk("ovs_fixed", 32'(gmask), 32'h3);
`endif
         end
         gm_prev = gmask;
      end
      req_valid_i = '0;
      for (int c = 0; c < 8 && busy_o; c++) cyc();
      chk("ovs_drain_busy", 32'(busy_o), 32'd0);
      chk("ovs_drain_sb", 32'(sbq.size()), 32'd0);

      // Flush with three buffers full
      set_req(0, 5'd10, 16'h3030);
      set_req(1, 5'd11, 16'h3131);
      set_req(3, 5'd12, 16'h3333);
      cyc();
      req_valid_i = '0;
      flush_i     = 1'b1;
      set_req(2, 5'd13, 16'h7777);
      #1;
      chk("flush_ready", 32'(req_ready_o), 32'd0);
      cyc();
      flush_i     = 1'b0;
      req_valid_i = '0;
      chk("flush_en",   32'({WB_en1, WB_en2}), 32'd0);
      chk("flush_busy", 32'(busy_o), 32'd0);
      set_req(2, 5'd9, 16'h9999);
      #1;
      chk("post_flush_ready", 32'(req_ready_o[2]), 32'd1);
      cyc();
      req_valid_i = '0;
      cyc();
      chk("post_flush_en1", 32'(WB_en1), 32'd1);
      chk("post_flush_tgt", 32'(WB_target1), 32'd9);
      chk("post_flush_dat", 32'(WB_data1), 32'h9999);
      cyc();
      chk("post_flush_sb", 32'(sbq.size()), 32'd0);

      // Reset asserted between edges clears the outputs at once
      set_req(0, 5'd20, 16'h4444);
      cyc();
      req_valid_i = '0;
      cyc();
      chk("arst_pre_en1", 32'(WB_en1), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_en1",  32'(WB_en1), 32'd0);
      chk("arst_dat1", 32'(WB_data1), 32'd0);
      chk("arst_busy", 32'(busy_o), 32'd0);
      sbq.delete();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Writeback scheduler for the register file's two write ports. Collects completed results from `NUM_REQ` producers (functional units / ROB retire lanes) through valid/ready handshakes, holds each in a one-entry buffer, and grants up to two buffered results per cycle onto the registered `WB_en1/2`, `WB_target1/2` and `WB_data1/2` outputs that drive the register file's data and valid arrays. Same-cycle writes to one register are never issued together.

## Interface
- `OPRAND_WIDTH`, 16, data width of one result
- `REGNAME_WIDTH`, 5, register address width
- `NUM_REQ`, 4, number of requesters (2..8)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `flush_i`  in  1  drop all buffered results and pending writes
- `req_valid_i`  in  `NUM_REQ`  requester k offers a result
- `req_ready_o`  out  `NUM_REQ`  requester k's offer is accepted this cycle
- `req_target_i`  in  `NUM_REQ`×`REGNAME_WIDTH`  destination register per requester
- `req_data_i`  in  `NUM_REQ`×`OPRAND_WIDTH`  result per requester
- `WB_en1`, `WB_en2`  out  1  write port 1/2 enable
- `WB_target1`, `WB_target2`  out  `REGNAME_WIDTH`  write address
- `WB_data1`, `WB_data2`  out  `OPRAND_WIDTH`  write data
- `busy_o`  out  1  any holding buffer full or any `WB_en` high

## Operation
- Per requester: holding register {full, target, data}. Handshake completes on `req_valid_i[k] && req_ready_o[k]`; the result is captured at that edge.
- `req_ready_o[k] = !flush_i && (!full[k] || grant[k])`. Grant depends only on holding state, never on `req_valid_i`, so no combinational loop.
- Arbitration per cycle, over full buffers only:
  - Slot 1 gets the first full buffer in priority order.
  - Slot 2 gets the next full buffer whose target differs from slot 1's target.
  - Buffers with a matching target are skipped this cycle and stay full.
- Granted buffers clear at the edge unless refilled by a same-cycle handshake. The granted entries load `WB_*1`/`WB_*2`. An unused slot loads `WB_en=0`; its target and data hold their previous values.
- Ordering: a single requester's results issue in acceptance order. Ordering across requesters to one register is the producers' responsibility.
- `flush_i` (synchronous):
  - At the edge, all `full` bits and both `WB_en` clear.
  - No handshake completes during the flush cycle.
  - The cycle after, behaviour is normal.
- Reset: all `full`=0, `WB_en1`=`WB_en2`=0, targets and data 0, priority pointer 0, `busy_o`=0, `req_ready_o`=all ones once `rst` is high and `flush_i` is low.

## Timing
- Handshake at edge N → buffer full in cycle N+1 → granted in N+1 → `WB_en` high in cycle N+2. Minimum latency is 2 cycles.
- Throughput: 2 writes per cycle. One requester sustains 1 result per cycle, because the grant re-opens `req_ready_o` in the same cycle.
- With 3 or more buffers full, the ungranted buffers wait. Round-robin rotation bounds the wait to ⌈`NUM_REQ`/2⌉ cycles, absent same-target conflicts.
- Same-target conflict: the second buffer issues one cycle later, so the second write lands last.
- Reset asserted mid-operation: outputs clear immediately, without waiting for a clock edge. In-flight buffered data is lost.

## Configuration
- `RF_WB_RR_EN` defined: round-robin priority. The pointer starts at 0. After a cycle with at least one grant, it moves to one past the highest-indexed (in rotation order) granted requester. With no grants, it holds.
- Not defined: fixed priority, requester 0 highest. The pointer logic is removed, so starvation of high indices is possible and accepted.

## Test plan
- Reset: `rst`=0 with valids high → `WB_en1/2`=0, `busy_o`=0. After release, all `req_ready_o`=1 and the first write appears 2 cycles after the handshake.
- Two requesters: req0 (r3, 0x1111) and req1 (r7, 0x2222) in the same cycle → 2 cycles later `WB_en1`=`WB_en2`=1 with (r3, 0x1111) and (r7, 0x2222).
- Same target: req0 and req1 both target r5 with 0xAAAA and 0xBBBB → cycle N+2 only port 1 writes r5=0xAAAA; cycle N+3 port 1 writes r5=0xBBBB; `WB_en2`=0 in both cycles.
- Oversubscription: all 4 requesters hold valid continuously (`RF_WB_RR_EN` on) → every requester is granted at least once in each 2-cycle window. Two writes issue per cycle, and every captured value appears exactly once.
- Back-to-back single requester: req2 streams 0x0001..0x0008 to r1..r8 → 8 consecutive cycles of port-1 writes in order, with `req_ready_o[2]` constant 1.
- Flush: 3 buffers full, then `flush_i`=1 for one cycle → no `WB_en` next cycle, `busy_o`=0, and that cycle's `req_ready_o`=0. A new request is then accepted normally.
